decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage between instruction fetch and dispatch. Accepts raw RV32I instructions with PC and branch prediction, decodes them, and buffers decoded entries in a DEPTH-entry FIFO with valid/ready handshakes on both sides. Compared with the purely combinational decoder, it adds:

- buffering and back-pressure;
- flush on misprediction;
- illegal-instruction detection;
- zeroing of unused register fields, so dispatch sees no false dependencies.

## Interface
Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2
- ADDR_W, 32, PC width
- OPNUM_W, 6, opnum width; codes come from the shared defines, with OPNUM_NULL = 0

Ports:
- clk_in  in  1  clock; everything is synchronous to its rising edge
- rst_in  in  1  reset, synchronous and active-low
- rdy_in  in  1  global enable; when low, all state holds
- flush_in  in  1  discard all buffered entries and any push this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue accepts; equals not full
- in_inst  in  32  raw instruction
- in_pc  in  ADDR_W  instruction PC
- in_pred_taken  in  1  fetch prediction
- out_valid  out  1  head entry valid; equals count != 0
- out_ready  in  1  dispatch consumes the head
- out_opnum  out  OPNUM_W  decoded operation
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_imm  out  32  decoded immediate
- out_pc  out  ADDR_W  PC of the head entry
- out_pred_taken  out  1  prediction of the head entry
- out_is_jump, out_is_ls, out_illegal  out  1 each  class flags
- count  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- push = rdy_in & in_valid & in_ready & !flush_in
- pop = rdy_in & out_valid & out_ready & !flush_in
- Decode is combinational on in_inst; the decoded entry is written at the write pointer on push.
- The out_* fields show the entry at the read pointer.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is updated as count + push − pop.
- Immediates:
  - I-type: sign-extended inst[31:20]
  - S-type: {inst[31:25], inst[11:7]}, sign-extended
  - B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended
  - U-type: {inst[31:12], 12'b0}
  - J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended
  - SLLI/SRLI/SRAI: imm is zero-extended inst[24:20]
  - R-type: imm = 0
- Register field zeroing:
  - rd forced to 0 for S and B
  - rs2 forced to 0 for I, U and J
  - rs1 forced to 0 for U and J
- out_is_jump is set for JAL, JALR and branches.
- out_is_ls is set for loads and stores.
- Illegal instruction: out_illegal = 1, opnum = OPNUM_NULL, and all fields are 0 except pc and pred_taken. An instruction is illegal if any of the following holds:
  - unknown opcode, or inst == 0
  - load funct3 is 3, 6 or 7
  - store funct3 is above 2
  - branch funct3 is 2 or 3
  - JALR funct3 is not 0
  - R-type funct7 is not 0x00 or 0x20
  - R-type funct7 is 0x20 with funct3 other than 0 or 5
  - SLLI funct7 is not 0
  - SRLI/SRAI funct7 is not 0x00 or 0x20
- Illegal entries are still enqueued, so the reorder buffer can trap in order.

## Timing
- Reset (rst_in = 0 at an edge):
  - pointers and count are cleared
  - out_valid = 0, in_ready = 1
  - all stored entries and out_* fields read 0
  - reset overrides flush_in and rdy_in
- Latency: a push at edge N shows out_valid = 1 with that entry from edge N onward. The minimum in-to-out latency is 1 cycle.
- Full (count == DEPTH): in_ready = 0, so in_valid is ignored. Space freed by a pop in the same cycle cannot be used that cycle; in_ready rises the following cycle.
- Empty: out_valid = 0 and out_ready is ignored. There is no bypass path.
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- Flush: with rdy_in = 1, the next edge empties the queue (pointers and count to 0). A push in the same cycle is dropped, and out_valid = 0 in the following cycle.
- With rdy_in = 0, flush_in is ignored.
- rdy_in = 0: pointers, count and entries hold; outputs hold their values.
- Handshakes: in_* must stay stable while in_valid = 1 and in_ready = 0. The out_* fields stay stable until pop.

## Test plan
- Push addi x1,x0,-1 (0xFFF00093) → next cycle out: opnum ADDI, rd 1, rs1 0, rs2 0, imm 0xFFFFFFFF, illegal 0.
- Push in sequence:
  - sw x2,8(x1) (0x0020A423) → rd 0, rs1 1, rs2 2, imm 8, is_ls 1
  - beq x0,x0,-4 (0xFE000EE3) → imm 0xFFFFFFFC, is_jump 1
  - jal x1,+2048 (0x001000EF) → imm 0x00000800, rs1 0, rs2 0
  - srai x3,x3,5 (0x4051D193) → opnum SRAI, imm 5
- Push 0x00000000 and 0x0000707F → both illegal = 1, opnum 0, and both still popped in order.
- Hold out_ready = 0 and push 5 entries with DEPTH 4 → count = 4, in_ready = 0, fifth held. Then pop one → fifth accepted the next cycle. Drain → FIFO order preserved across pointer wrap.
- With 3 entries queued, assert flush_in together with in_valid → next cycle count = 0, out_valid = 0, and the pushed instruction never appears.
- With rdy_in = 0 for 3 cycles, drive push, pop and flush → no state change. Then assert rst_in = 0 mid-fill → count = 0, in_ready = 1.

Source files
------------

// File: rtl/decode_queue.sv
// RV32I decode stage: combinational decode of the fetch word into a DEPTH-entry
// FIFO of decoded entries, with flush, illegal detection and unused-field zeroing.
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int OPNUM_W = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic                     in_pred_taken,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPNUM_W-1:0]       out_opnum,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_imm,
    output logic [ADDR_W-1:0]        out_pc,
    output logic                     out_pred_taken,
    output logic                     out_is_jump,
    output logic                     out_is_ls,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F,
                           OPC_JALR = 7'h67, OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03,
                           OPC_STORE = 7'h23, OPC_OPIMM = 7'h13, OPC_OP = 7'h33;

    localparam logic [OPNUM_W-1:0]
        OP_LUI  = OPNUM_W'(1),  OP_AUIPC = OPNUM_W'(2),  OP_JAL  = OPNUM_W'(3),
        OP_JALR = OPNUM_W'(4),  OP_BEQ   = OPNUM_W'(5),  OP_BNE  = OPNUM_W'(6),
        OP_BLT  = OPNUM_W'(7),  OP_BGE   = OPNUM_W'(8),  OP_BLTU = OPNUM_W'(9),
        OP_BGEU = OPNUM_W'(10), OP_LB    = OPNUM_W'(11), OP_LH   = OPNUM_W'(12),
        OP_LW   = OPNUM_W'(13), OP_LBU   = OPNUM_W'(14), OP_LHU  = OPNUM_W'(15),
        OP_SB   = OPNUM_W'(16), OP_SH    = OPNUM_W'(17), OP_SW   = OPNUM_W'(18),
        OP_ADDI = OPNUM_W'(19), OP_SLTI  = OPNUM_W'(20), OP_SLTIU = OPNUM_W'(21),
        OP_XORI = OPNUM_W'(22), OP_ORI   = OPNUM_W'(23), OP_ANDI = OPNUM_W'(24),
        OP_SLLI = OPNUM_W'(25), OP_SRLI  = OPNUM_W'(26), OP_SRAI = OPNUM_W'(27),
        OP_ADD  = OPNUM_W'(28), OP_SUB   = OPNUM_W'(29), OP_SLL  = OPNUM_W'(30),
        OP_SLT  = OPNUM_W'(31), OP_SLTU  = OPNUM_W'(32), OP_XOR  = OPNUM_W'(33),
        OP_SRL  = OPNUM_W'(34), OP_SRA   = OPNUM_W'(35), OP_OR   = OPNUM_W'(36),
        OP_AND  = OPNUM_W'(37);

    typedef struct packed {
        logic [OPNUM_W-1:0] opnum;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [31:0]        imm;
        logic [ADDR_W-1:0]  pc;
        logic               pred;
        logic               jump;
        logic               ls;
        logic               ill;
    } entry_t;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    entry_t      dec;
    logic        ill;

    assign opc    = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u  = {in_inst[31:12], 12'b0};
    assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign imm_sh = {27'b0, in_inst[24:20]};

    always_comb begin
        dec     = '0;
        ill     = 1'b0;
        dec.rd  = in_inst[11:7];
        dec.rs1 = in_inst[19:15];
        dec.rs2 = in_inst[24:20];
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec.opnum = (opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
                dec.imm = imm_u; dec.rs1 = '0; dec.rs2 = '0;
            end
            OPC_JAL: begin
                dec.opnum = OP_JAL; dec.imm = imm_j; dec.rs1 = '0; dec.rs2 = '0; dec.jump = 1'b1;
            end
            OPC_JALR: begin
                dec.opnum = OP_JALR; dec.imm = imm_i; dec.rs2 = '0; dec.jump = 1'b1;
                ill = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                dec.imm = imm_b; dec.rd = '0; dec.jump = 1'b1;
                case (f3)
                    3'd0: dec.opnum = OP_BEQ;
                    3'd1: dec.opnum = OP_BNE;
                    3'd4: dec.opnum = OP_BLT;
                    3'd5: dec.opnum = OP_BGE;
                    3'd6: dec.opnum = OP_BLTU;
                    3'd7: dec.opnum = OP_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.imm = imm_i; dec.rs2 = '0; dec.ls = 1'b1;
                case (f3)
                    3'd0: dec.opnum = OP_LB;
                    3'd1: dec.opnum = OP_LH;
                    3'd2: dec.opnum = OP_LW;
                    3'd4: dec.opnum = OP_LBU;
                    3'd5: dec.opnum = OP_LHU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec.imm = imm_s; dec.rd = '0; dec.ls = 1'b1;
                case (f3)
                    3'd0: dec.opnum = OP_SB;
                    3'd1: dec.opnum = OP_SH;
                    3'd2: dec.opnum = OP_SW;
                    default: ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec.imm = imm_i; dec.rs2 = '0;
                case (f3)
                    3'd0: dec.opnum = OP_ADDI;
                    3'd2: dec.opnum = OP_SLTI;
                    3'd3: dec.opnum = OP_SLTIU;
                    3'd4: dec.opnum = OP_XORI;
                    3'd6: dec.opnum = OP_ORI;
                    3'd7: dec.opnum = OP_ANDI;
                    3'd1: begin
                        dec.opnum = OP_SLLI; dec.imm = imm_sh;
                        ill = (f7 != 7'h00);
                    end
                    default: begin
                        dec.opnum = f7[5] ? OP_SRAI : OP_SRLI; dec.imm = imm_sh;
                        ill = (f7 != 7'h00) && (f7 != 7'h20);
                    end
                endcase
            end
            OPC_OP: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: dec.opnum = OP_ADD;
                        3'd1: dec.opnum = OP_SLL;
                        3'd2: dec.opnum = OP_SLT;
                        3'd3: dec.opnum = OP_SLTU;
                        3'd4: dec.opnum = OP_XOR;
                        3'd5: dec.opnum = OP_SRL;
                        3'd6: dec.opnum = OP_OR;
                        default: dec.opnum = OP_AND;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    dec.opnum = OP_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    dec.opnum = OP_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (in_inst == 32'h0) ill = 1'b1;
        // Illegal entries carry only pc/prediction so the ROB can trap in order.
        if (ill) begin
            dec     = '0;
            dec.ill = 1'b1;
        end
        dec.pc   = in_pc;
        dec.pred = in_pred_taken;
    end

    entry_t            mem_q [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push, pop;

    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = rdy_in & in_valid & in_ready & ~flush_in;
    assign pop       = rdy_in & out_valid & out_ready & ~flush_in;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (rdy_in) begin
            if (flush_in) begin
                wptr_d = '0;
                rptr_d = '0;
                cnt_d  = '0;
            end else begin
                if (push) wptr_d = wptr_q + PTR_W'(1);
                if (pop)  rptr_d = rptr_q + PTR_W'(1);
                cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) mem_q[wptr_q] <= dec;
        end
    end

    assign head           = mem_q[rptr_q];
    assign out_opnum      = head.opnum;
    assign out_rd         = head.rd;
    assign out_rs1        = head.rs1;
    assign out_rs2        = head.rs2;
    assign out_imm        = head.imm;
    assign out_pc         = head.pc;
    assign out_pred_taken = head.pred;
    assign out_is_jump    = head.jump;
    assign out_is_ls      = head.ls;
    assign out_illegal    = head.ill;
    assign count          = cnt_q;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: table of decode vectors plus hand-written
// sequences for full, wrap, flush, stall and reset-mid-fill behaviour.
module tb_decode_queue;
    logic        clk_in = 1'b0, rst_in, rdy_in, flush_in, in_valid, in_pred_taken, out_ready;
    logic [31:0] in_inst, in_pc;
    logic        in_ready, out_valid, out_pred_taken, out_is_jump, out_is_ls, out_illegal;
    logic [5:0]  out_opnum;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm, out_pc;
    logic [2:0]  count;

    int n_cmp = 0, n_fail = 0;

    decode_queue #(.DEPTH(4), .ADDR_W(32), .OPNUM_W(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
        .out_opnum(out_opnum), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_pc(out_pc), .out_pred_taken(out_pred_taken),
        .out_is_jump(out_is_jump), .out_is_ls(out_is_ls), .out_illegal(out_illegal),
        .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        jmp, ls, ill;
    } vec_t;

    vec_t vt [14];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_addi(input int k);
        return {12'(k + 1), 5'd0, 3'd0, 5'(k + 1), 7'h13};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic acc;
        vt[0]  = '{32'hFFF00093, 6'd19, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{32'h0020A423, 6'd18, 5'd0, 5'd1, 5'd2, 32'h00000008, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{32'hFE000EE3, 6'd5,  5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{32'h001000EF, 6'd3,  5'd1, 5'd0, 5'd0, 32'h00000800, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{32'h4051D193, 6'd27, 5'd3, 5'd3, 5'd0, 32'h00000005, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{32'h00000000, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'h0000707F, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{32'h00432283, 6'd13, 5'd5, 5'd6, 5'd0, 32'h00000004, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{32'h123453B7, 6'd1,  5'd7, 5'd0, 5'd0, 32'h12345000, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{32'h402081B3, 6'd29, 5'd3, 5'd1, 5'd2, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vt[10] = '{32'h4020C1B3, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[11] = '{32'h00433283, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[12] = '{32'h000290E7, 6'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vt[13] = '{32'h00C280E7, 6'd4,  5'd1, 5'd5, 5'd0, 32'h0000000C, 1'b1, 1'b0, 1'b0};

        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; in_pred_taken = 1'b0;
        step(); step();
        chk("rst count", 32'(count), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_imm", out_imm, 32'd0);
        chk("rst out_opnum", 32'(out_opnum), 32'd0);
        rst_in = 1'b1;
        step();

        // Decode table: each vector is pushed, checked at the head, then popped.
        for (int i = 0; i < 14; i++) begin
            in_inst = vt[i].inst; in_pc = 32'h1000 + 32'(i * 4); in_pred_taken = 1'((i & 1));
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d count", i), 32'(count), 32'd1);
            chk($sformatf("v%0d opnum", i), 32'(out_opnum), 32'(vt[i].op));
            chk($sformatf("v%0d rd", i), 32'(out_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d rs1", i), 32'(out_rs1), 32'(vt[i].rs1));
            chk($sformatf("v%0d rs2", i), 32'(out_rs2), 32'(vt[i].rs2));
            chk($sformatf("v%0d imm", i), out_imm, vt[i].imm);
            chk($sformatf("v%0d flags", i), {29'd0, out_is_jump, out_is_ls, out_illegal},
                {29'd0, vt[i].jmp, vt[i].ls, vt[i].ill});
            chk($sformatf("v%0d pc", i), out_pc, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d pred", i), 32'(out_pred_taken), 32'((i & 1)));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d pop count", i), 32'(count), 32'd0);
        end

        // Two illegal words back to back, second pushed while the first pops.
        in_valid = 1'b1; in_inst = 32'h0; in_pc = 32'hA0;
        step();
        in_inst = 32'h0000707F; in_pc = 32'hB0; out_ready = 1'b1;
        chk("ill0 head pc", out_pc, 32'hA0);
        chk("ill0 illegal", 32'(out_illegal), 32'd1);
        step();
        in_valid = 1'b0;
        chk("pushpop count", 32'(count), 32'd1);
        chk("ill1 head pc", out_pc, 32'hB0);
        chk("ill1 illegal", 32'(out_illegal), 32'd1);
        step();
        out_ready = 1'b0;
        chk("ill drain count", 32'(count), 32'd0);

        // Fill to full with dispatch stalled; fifth push must wait.
        k = 0; in_valid = 1'b1; in_pc = 32'h0;
        for (int cyc = 0; cyc < 12 && k < 4; cyc++) begin
            in_inst = mk_addi(k);
            acc = in_ready;
            step();
            if (acc) k++;
        end
        chk("fill accepted", 32'(k), 32'd4);
        in_inst = mk_addi(4);
        step(); step();
        chk("full count", 32'(count), 32'd4);
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full head imm", out_imm, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full pop count", 32'(count), 32'd3);
        chk("full pop in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("fifth count", 32'(count), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d imm", j), out_imm, 32'(j + 2));
            chk($sformatf("drain%0d rd", j), 32'(out_rd), 32'(j + 2));
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        chk("drain count", 32'(count), 32'd0);

        // Flush with three queued and a concurrent push.
        in_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_inst = mk_addi(j);
            step();
        end
        chk("preflush count", 32'(count), 32'd3);
        in_inst = mk_addi(9); flush_in = 1'b1;
        step();
        flush_in = 1'b0; in_valid = 1'b0;
        chk("flush count", 32'(count), 32'd0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        step();
        chk("flush no ghost", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_inst = mk_addi(7);
        step();
        in_inst = mk_addi(3);
        step();
        in_valid = 1'b0;
        chk("postflush count", 32'(count), 32'd2);
        chk("postflush head", out_imm, 32'd8);

        // Stall: push, pop and flush all requested while rdy_in is low.
        rdy_in = 1'b0; in_valid = 1'b1; in_inst = mk_addi(5); out_ready = 1'b1; flush_in = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("stall%0d count", j), 32'(count), 32'd2);
            chk($sformatf("stall%0d head", j), out_imm, 32'd8);
        end
        rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b0;
        step();
        chk("resume count", 32'(count), 32'd3);
        rst_in = 1'b0;
        step();
        rst_in = 1'b1; in_valid = 1'b0;
        chk("midrst count", 32'(count), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_imm", out_imm, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
